// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder/subtractor. One full_adder cell is fed one
// operand bit pair per clock with a registered carry; the sum bits are
// shifted into a result register. Start/busy/done handshake.

// Single-bit full adder cell.
module full_adder (
  input  logic Ai,
  input  logic Bi,
  input  logic Cini,
  output logic Di,
  output logic Couti
);
  assign Di    = Ai ^ Bi ^ Cini;
  assign Couti = (Ai & Bi) | (Cini & (Ai ^ Bi));
endmodule

module serial_add_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_next;
  logic             fa_d;
  logic             fa_co;

  full_adder u_fa (
    .Ai    (a_sh[0]),
    .Bi    (b_sh[0]),
    .Cini  (carry),
    .Di    (fa_d),
    .Couti (fa_co)
  );

  // Incoming sum bit enters at the MSB; after WIDTH shifts it holds the full result.
  assign res_next = {fa_d, res};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and datapath strobes; start is honoured in IDLE and DONE only.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and result capture.
  // On the final bit the carry register still holds the carry into the MSB,
  // so overflow is taken directly from it rather than from a separate latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      D     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= op_sub ? ~B : B;
      carry <= op_sub | cin;
      cnt   <= '0;
      res   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      res   <= res_next[WIDTH-1:1];
      if (last_bit) begin
        D    <= res_next;
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: WIDTH=32 directed table plus
// handshake corner cases, and an exhaustive back-to-back sweep at WIDTH=4.
module tb_serial_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        start, op_sub, cin;
  logic [31:0] a, b, d;
  logic        busy, done, cout, ovf;

  // WIDTH=4 instance
  logic        start4, op_sub4, cin4;
  logic [3:0]  a4, b4, d4;
  logic        busy4, done4, cout4, ovf4;

  serial_add_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .cin(cin),
    .A(a), .B(b), .busy(busy), .done(done), .D(d), .cout(cout), .ovf(ovf)
  );

  serial_add_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_sub(op_sub4), .cin(cin4),
    .A(a4), .B(b4), .busy(busy4), .done(done4), .D(d4), .cout(cout4), .ovf(ovf4)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_d = '0;

  typedef struct {
    logic        sub;
    logic        c;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ed;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // busy and done must never overlap
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((busy && done) || (busy4 && done4)) begin
        errors++;
        $display("FAIL busy_done_overlap: got busy=%0b/%0b done=%0b/%0b expected no overlap",
                 busy, busy4, done, done4);
      end
    end
  end

  // One WIDTH=32 operation. inject>0 pulses a conflicting start at that RUN cycle.
  task automatic op32(input string name, input logic s, input logic c,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ed, input logic ec, input logic eo,
                      input int inject);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    @(negedge clk);
    op_sub = s; cin = c; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_sub = ~s; cin = ~c; a = ~x; b = ~y;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      if (nb == 16) check({name, "_hold_d"}, d, last_d);
      if (inject > 0 && nb == inject) begin
        start = 1'b1; op_sub = 1'b0; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_busy_cycles"}, nb, 32'd32);
    check({name, "_d"}, d, ed);
    check({name, "_cout_ovf"}, {30'd0, cout, ovf}, {30'd0, ec, eo});
    last_d = ed;
    @(negedge clk);
    check({name, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  function automatic logic [5:0] model4(input int n);
    logic [3:0] x, y, bx, s;
    logic [4:0] sum;
    logic       c, ov;
    x   = 4'((n / 16) % 16);
    y   = 4'(n % 16);
    bx  = (n >= 512) ? ~y : y;
    c   = (n >= 512) ? 1'b1 : ((n >= 256) ? 1'b1 : 1'b0);
    sum = {1'b0, x} + {1'b0, bx} + {4'd0, c};
    s   = sum[3:0];
    ov  = (x[3] == bx[3]) && (s[3] != x[3]);
    return {ov, sum[4], s};
  endfunction

  task automatic set4(input int n);
    a4      = 4'((n / 16) % 16);
    b4      = 4'(n % 16);
    op_sub4 = (n >= 512);
    cin4    = (n >= 256 && n < 512);
  endtask

  initial begin
    int nb;
    int dn;
    bit seen;

    vecs[0] = '{1'b0, 1'b0, 32'd5,        32'd3,        32'd8,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'd7,        32'd5,        32'd2,        1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'd10,       32'd10,       32'd0,        1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start4 = 1'b0; op_sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("reset_32", {busy, done, cout, ovf, d}, 36'd0);
    check("reset_4", {26'd0, busy4, done4, cout4, ovf4, d4}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      op32($sformatf("vec%0d", i), vecs[i].sub, vecs[i].c, vecs[i].x, vecs[i].y,
           vecs[i].ed, vecs[i].ec, vecs[i].eo, 0);

    // start while busy is ignored
    op32("inject", 1'b0, 1'b0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 10);

    // reset mid-RUN aborts without a done pulse
    @(negedge clk);
    op_sub = 1'b0; cin = 1'b0; a = 32'h100; b = 32'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_state", {busy, done, cout, ovf, d}, 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("abort_no_done", dn, 32'd0);
    last_d = '0;
    op32("after_abort", 1'b0, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 0);

    // WIDTH=4 exhaustive sweep with back-to-back starts issued in DONE
    @(negedge clk);
    set4(0);
    start4 = 1'b1;
    for (int n = 0; n < 768; n++) begin
      @(negedge clk);
      start4 = 1'b0;
      nb = 0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (done4) begin
          seen = 1'b1;
          break;
        end
        if (busy4) nb++;
        @(negedge clk);
      end
      check($sformatf("w4_seen_busy n=%0d", n), {seen, 31'(nb)}, {1'b1, 31'd4});
      check($sformatf("w4_result n=%0d", n), {26'd0, ovf4, cout4, d4}, {26'd0, model4(n)});
      if (n < 767) begin
        set4(n + 1);
        start4 = 1'b1;
      end
    end
    @(negedge clk);
    check("w4_done_width", {31'd0, done4}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
